loop_seq_checker: RTL and testbench

LOOP_SEQ_CHECKER -- requirements
Module: loop_seq_checker

---
 rtl/loop_seq_checker.sv | 172 +++++++++++++++++
 tb/tb_loop_seq_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_seq_checker.sv
// Nested-loop strobe sequence checker with sticky first-error capture.
// Optional idle timeout in RUN: define LOOP_SEQ_CHK_TIMEOUT_EN.
module loop_seq_checker #(
    parameter int unsigned OUTER_N = 10,
    parameter int unsigned INNER_N = 10,
    parameter int unsigned TMO_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       outer_stb,
    input  logic       inner_stb,
    input  logic [7:0] act_val,
    input  logic       err_clr,
    output logic [7:0] outer_cnt,
    output logic [7:0] inner_cnt,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] pass_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] ON = OUTER_N[7:0];
    localparam logic [7:0] IN = INNER_N[7:0];

    if (OUTER_N == 0 || INNER_N == 0 || TMO_CYC == 0) begin : g_bad_param
        $error("loop_seq_checker: parameters must be non-zero");
    end

    state_t     state_q, state_d;
    logic [7:0] outer_q, outer_d;
    logic [7:0] inner_q, inner_d;
    logic [7:0] pass_q, pass_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [2:0] code_q, code_d;
    logic       fail;
    logic [2:0] fcode;

`ifdef LOOP_SEQ_CHK_TIMEOUT_EN
    localparam logic [15:0] TMO = TMO_CYC[15:0];
    logic [15:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            outer_q <= '0;
            inner_q <= '0;
            pass_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        outer_d = outer_q;
        inner_d = inner_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        fail    = 1'b0;
        fcode   = 3'd0;
`ifdef LOOP_SEQ_CHK_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (err_clr) begin
            state_d = IDLE;
            err_d   = 1'b0;
            code_d  = 3'd0;
            outer_d = '0;
            inner_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (outer_stb && inner_stb) begin
                        fail  = 1'b1;
                        fcode = 3'd4;
                    end else if (outer_stb) begin
                        state_d = RUN;
                        outer_d = 8'd1;
                        inner_d = 8'd0;
                    end else if (inner_stb) begin
                        fail  = 1'b1;
                        fcode = 3'd6;
                    end
                end
                RUN: begin
                    if (outer_stb && inner_stb) begin
                        fail  = 1'b1;
                        fcode = 3'd4;
                    end else if (outer_stb) begin
                        if (inner_q != IN) begin
                            fail  = 1'b1;
                            fcode = 3'd1;
                        end else if (outer_q != ON) begin
                            outer_d = outer_q + 8'd1;
                            inner_d = 8'd0;
                        end else begin
                            fail  = 1'b1;
                            fcode = 3'd2;
                        end
                    end else if (inner_stb) begin
                        if (inner_q == IN) begin
                            fail  = 1'b1;
                            fcode = 3'd2;
                        end else if (act_val != outer_q) begin
                            fail  = 1'b1;
                            fcode = 3'd3;
                        end else if (inner_q + 8'd1 == IN && outer_q == ON) begin
                            // last inner of last outer closes the sequence
                            state_d = IDLE;
                            done_d  = 1'b1;
                            pass_d  = pass_q + 8'd1;
                            outer_d = '0;
                            inner_d = '0;
                        end else begin
                            inner_d = inner_q + 8'd1;
                        end
                    end else begin
`ifdef LOOP_SEQ_CHK_TIMEOUT_EN
                        if (tmo_q + 16'd1 == TMO) begin
                            fail  = 1'b1;
                            fcode = 3'd5;
                        end else begin
                            tmo_d = tmo_q + 16'd1;
                        end
`endif
                    end
                end
                default: ;
            endcase
            // counters keep their pre-error values on entry to ERR
            if (fail) begin
                state_d = ERR;
                err_d   = 1'b1;
                code_d  = fcode;
                outer_d = outer_q;
                inner_d = inner_q;
            end
        end
    end

    assign outer_cnt = outer_q;
    assign inner_cnt = inner_q;
    assign pass_cnt  = pass_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_loop_seq_checker.sv
// Randomized bench for loop_seq_checker against a rule-level model.
module tb_loop_seq_checker;

    localparam int ON  = 10;
    localparam int IN  = 10;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       outer_stb = 1'b0;
    logic       inner_stb = 1'b0;
    logic [7:0] act_val = 8'd0;
    logic       err_clr = 1'b0;
    logic [7:0] outer_cnt;
    logic [7:0] inner_cnt;
    logic       done;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] pass_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    int m_st = 0;
    int m_outer = 0;
    int m_inner = 0;
    int m_pass = 0;
    int m_code = 0;
    int m_idle = 0;
    int m_err = 0;
    int m_done = 0;

    loop_seq_checker #(
        .OUTER_N(ON),
        .INNER_N(IN),
        .TMO_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .outer_stb(outer_stb),
        .inner_stb(inner_stb),
        .act_val(act_val),
        .err_clr(err_clr),
        .outer_cnt(outer_cnt),
        .inner_cnt(inner_cnt),
        .done(done),
        .err(err),
        .err_code(err_code),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_fail(input int code);
        m_st   = 2;
        m_err  = 1;
        m_code = code;
        m_idle = 0;
    endtask

    task automatic m_reset();
        m_st = 0; m_outer = 0; m_inner = 0; m_pass = 0;
        m_code = 0; m_idle = 0; m_err = 0; m_done = 0;
    endtask

    // outputs expected after the coming clock edge, from the sequence rules
    task automatic model_step(input bit o, input bit i, input int v, input bit c);
        m_done = 0;
        if (c) begin
            m_st = 0; m_err = 0; m_code = 0;
            m_outer = 0; m_inner = 0; m_idle = 0;
        end else if (m_st == 2) begin
        end else if (o && i) begin
            m_fail(4);
        end else if (m_st == 0) begin
            if (o) begin
                m_st = 1; m_outer = 1; m_inner = 0; m_idle = 0;
            end else if (i) begin
                m_fail(6);
            end
        end else if (o) begin
            m_idle = 0;
            if (m_inner < IN) m_fail(1);
            else if (m_outer < ON) begin
                m_outer++; m_inner = 0;
            end else m_fail(2);
        end else if (i) begin
            m_idle = 0;
            if (m_inner == IN) m_fail(2);
            else if (v != m_outer) m_fail(3);
            else begin
                m_inner++;
                if (m_inner == IN && m_outer == ON) begin
                    m_done = 1;
                    m_pass = (m_pass + 1) % 256;
                    m_st = 0; m_outer = 0; m_inner = 0;
                end
            end
        end else begin
`ifdef LOOP_SEQ_CHK_TIMEOUT_EN
            m_idle++;
            if (m_idle >= TMO) m_fail(5);
`endif
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("outer_cnt", 32'(outer_cnt), 32'(m_outer));
        chk("inner_cnt", 32'(inner_cnt), 32'(m_inner));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
        if (done === 1'b1) done_seen++;
    end

    task automatic drive(input bit o, input bit i, input int v, input bit c);
        @(negedge clk);
        outer_stb = o;
        inner_stb = i;
        act_val   = v[7:0];
        err_clr   = c;
        model_step(o, i, v, c);
    endtask

    task automatic look();
        @(posedge clk);
        #3;
    endtask

    task automatic outer_iter(input int k, input int n);
        drive(1'b1, 1'b0, 0, 1'b0);
        for (int j = 0; j < n; j++) drive(1'b0, 1'b1, k, 1'b0);
    endtask

    task automatic full_seq();
        for (int k = 1; k <= ON; k++) outer_iter(k, IN);
    endtask

    initial begin
        int d0;
        int r;
        #1;
        chk("rst_outer", 32'(outer_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pass", 32'(pass_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // one clean sequence
        d0 = done_seen;
        full_seq();
        look();
        chk("seq_done", 32'(done), 1);
        drive(1'b0, 1'b0, 0, 1'b0);
        look();
        chk("seq_done_cnt", 32'(done_seen - d0), 1);
        chk("seq_pass", 32'(pass_cnt), 1);
        chk("seq_err", 32'(err), 0);

        // short inner loop
        outer_iter(1, IN);
        outer_iter(2, IN);
        outer_iter(3, 7);
        drive(1'b1, 1'b0, 0, 1'b0);
        look();
        chk("short_code", 32'(err_code), 1);
        chk("short_outer", 32'(outer_cnt), 3);
        chk("short_inner", 32'(inner_cnt), 7);
        drive(1'b0, 1'b0, 0, 1'b1);

        // data mismatch, then clear
        outer_iter(1, IN);
        outer_iter(2, 4);
        drive(1'b0, 1'b1, 5, 1'b0);
        look();
        chk("data_code", 32'(err_code), 3);
        drive(1'b1, 1'b1, 0, 1'b1);
        look();
        chk("clr_err", 32'(err), 0);
        chk("clr_outer", 32'(outer_cnt), 0);
        chk("clr_pass", 32'(pass_cnt), 1);

        // simultaneous strobes, extra inner, orphan inner
        drive(1'b1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, 0, 1'b0);
        look();
        chk("both_code", 32'(err_code), 4);
        drive(1'b0, 1'b0, 0, 1'b1);
        outer_iter(1, IN + 1);
        look();
        chk("extra_code", 32'(err_code), 2);
        drive(1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b1, 0, 1'b0);
        look();
        chk("orphan_code", 32'(err_code), 6);
        drive(1'b0, 1'b0, 0, 1'b1);

        // strobe-free wait in RUN
        drive(1'b1, 1'b0, 0, 1'b0);
        for (int j = 0; j < TMO; j++) drive(1'b0, 1'b0, 0, 1'b0);
        look();
`ifdef LOOP_SEQ_CHK_TIMEOUT_EN
        chk("tmo_code", 32'(err_code), 5);
`else
        chk("tmo_err", 32'(err), 0);
`endif
        drive(1'b0, 1'b0, 0, 1'b1);

        // asynchronous reset mid-sequence
        for (int k = 1; k <= 4; k++) outer_iter(k, IN);
        outer_iter(5, 3);
        @(negedge clk);
        rst_n = 1'b0;
        outer_stb = 1'b0;
        inner_stb = 1'b0;
        act_val = 8'd0;
        err_clr = 1'b0;
        m_reset();
        #1;
        chk("arst_outer", 32'(outer_cnt), 0);
        chk("arst_inner", 32'(inner_cnt), 0);
        chk("arst_pass", 32'(pass_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_seen;
        full_seq();
        drive(1'b0, 1'b0, 0, 1'b0);
        look();
        chk("arst_seq_done", 32'(done_seen - d0), 1);
        chk("arst_seq_pass", 32'(pass_cnt), 1);

        // randomized traffic, mostly legal
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(99));
            if (r < 6) begin
                drive(1'($urandom_range(1)), 1'($urandom_range(1)),
                      int'($urandom_range(11)), ($urandom_range(9) == 0));
            end else if (r < 14) begin
                drive(1'b0, 1'b0, 0, 1'b0);
            end else if (m_st == 0) begin
                drive(1'b1, 1'b0, 0, 1'b0);
            end else if (m_st == 1) begin
                if (m_inner < IN) drive(1'b0, 1'b1, m_outer, 1'b0);
                else drive(1'b1, 1'b0, 0, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 0, 1'b1);
            end
        end
        drive(1'b0, 1'b0, 0, 1'b0);
        look();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
